// File: rtl/mul_acc_pkg.sv
`default_nettype none
// ============================================================================
// Package : mul_acc_pkg
// Purpose : Shared widths, result-entry type and pointer-width helper for the
//           multiplier product collector (mul_acc_collector / mul_acc_fifo).
// Contents: default parameter values, res_entry_t, ptr_w()
// Revision: 1.0 - initial release
// ============================================================================
package mul_acc_pkg;

  localparam int IN_W_DEF   = 16;  // 8x8 multiplier product width
  localparam int ACC_W_DEF  = 18;  // holds 4*255*255 without clipping
  localparam int COUNT_DEF  = 4;
  localparam int DEPTH_DEF  = 4;

  // FIFO entries carry the widest supported result; the top only drives and
  // reads the low ACC_W bits so one entry type serves every configuration.
  localparam int DATA_MAX_W = 32;
  localparam int CNT_W      = 5;   // COUNT up to 16 needs 5 bits

  typedef struct packed {
    logic [DATA_MAX_W-1:0] data;
    logic                  sat;
    logic [CNT_W-1:0]      cnt;
  } res_entry_t;

  // One extra MSB beyond the address lets full and empty be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_acc_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mul_acc_fifo
// Purpose : Synchronous result FIFO. A push arriving while full is dropped
//           unless a pop happens on the same edge.
// Ports   : clk, rst_n          - clock, async active-low reset
//           push, push_entry    - write request and data
//           pop                 - read request (ignored when empty)
//           head                - current head entry, all-zero when empty
//           empty               - no entries held
//           level               - occupied entries
//           drop                - this cycle's push is being discarded
// Revision: 1.0 - initial release
// ============================================================================
module mul_acc_fifo
  import mul_acc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  res_entry_t             push_entry,
  input  logic                   pop,
  output res_entry_t             head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  res_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot address but different wrap bit: writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // No bypass: an empty FIFO reads as zero even while being written.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_acc_collector.sv
`default_nettype none
// ============================================================================
// Module  : mul_acc_collector
// Purpose : Sums groups of COUNT valid multiplier products (saturating) and
//           queues each group result for a valid/ready consumer. The input
//           is never stalled; a result that finds the FIFO full is dropped
//           and recorded in a sticky error flag.
// Ports   : clk, rst_n              - clock, async active-low reset
//           prod_valid, prod_data   - product stream from the multiplier
//           flush                   - close a non-empty group early
//           clr_err                 - clear drop_err
//           res_valid, res_ready    - output handshake
//           res_data/res_sat/res_cnt- head result, saturation flag, count
//           fifo_level              - occupied FIFO entries
//           drop_err                - sticky result-lost flag
// Revision: 1.0 - initial release
// ============================================================================
module mul_acc_collector
  import mul_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prod_valid,
  input  logic [IN_W-1:0]        prod_data,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data,
  output logic                   res_sat,
  output logic [CNT_W-1:0]       res_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   drop_err
);

  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W:0]   raw_sum;
  logic [ACC_W-1:0] next_sum;
  logic             next_sat;
  logic [CNT_W-1:0] next_cnt;
  logic             close;

  res_entry_t       push_entry;
  res_entry_t       head;
  logic             empty;
  logic             drop;

  // One guard bit above the accumulator exposes a clipping addition.
  assign raw_sum = {1'b0, acc} + (ACC_W+1)'(prod_data);

  // Group state as it would be after this cycle's product; also the value
  // pushed when the group closes on this edge.
  always_comb begin
    next_sum = acc;
    next_sat = sat;
    next_cnt = cnt;
    if (prod_valid) begin
      next_sum = raw_sum[ACC_W] ? '1 : raw_sum[ACC_W-1:0];
      next_sat = sat | raw_sum[ACC_W];
      next_cnt = cnt + CNT_W'(1);
    end
  end

  // Flush together with the COUNT-th product is still a single close.
  assign close = (prod_valid && (next_cnt == CNT_W'(COUNT)))
              || (flush && ((cnt != '0) || prod_valid));

  always_comb begin
    push_entry      = '0;
    push_entry.data = DATA_MAX_W'(next_sum);
    push_entry.sat  = next_sat;
    push_entry.cnt  = next_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
      cnt <= '0;
    end else if (close) begin
      acc <= '0;
      sat <= 1'b0;
      cnt <= '0;
    end else if (prod_valid) begin
      acc <= next_sum;
      sat <= next_sat;
      cnt <= next_cnt;
    end
  end

  mul_acc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (close),
    .push_entry(push_entry),
    .pop       (res_valid && res_ready),
    .head      (head),
    .empty     (empty),
    .level     (fifo_level),
    .drop      (drop)
  );

  assign res_valid = !empty;
  assign res_data  = head.data[ACC_W-1:0];
  assign res_sat   = head.sat;
  assign res_cnt   = head.cnt;

  // Entry bits above ACC_W are always written as zero and never presented.
  generate
    if (ACC_W < DATA_MAX_W) begin : g_head_pad
      logic unused_head_hi;
      assign unused_head_hi = |head.data[DATA_MAX_W-1:ACC_W];
    end
  endgenerate

  // Set has priority so a drop coinciding with clr_err is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end else if (clr_err) begin
      drop_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/mul_acc_collector.md
Name: mul_acc_collector

Overview:
- Downstream consumer of the 8x8 pipelined multiplier.
- Takes the multiplier's product/enable stream and sums groups of COUNT consecutive valid products into one result.
- Queues each result in a small FIFO and presents it on a valid/ready output interface.
- The multiplier cannot be stalled, so the collector never back-pressures its input; overflow is flagged instead.

Parameters:
- IN_W, 16, product width; matches the multiplier output (2*8).
- ACC_W, 18, accumulator/result width; 18 holds 4*255*255 without overflow.
- COUNT, 4, products per result; legal range 2..16.
- DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- prod_valid  input  1  product valid; driven by the multiplier's mul_en_out
- prod_data  input  IN_W  product; driven by the multiplier's mul_out
- flush  input  1  close the current group early
- clr_err  input  1  clear the sticky error flag
- res_valid  output  1  FIFO head valid
- res_ready  input  1  downstream accepts the head
- res_data  output  ACC_W  head result
- res_sat  output  1  head result saturated
- res_cnt  output  5  number of products summed into the head result
- fifo_level  output  clog2(DEPTH)+1  occupied entries
- drop_err  output  1  sticky: a result was lost because the FIFO was full

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): accumulator, group counter, FIFO pointers, res_valid, res_data, res_sat, res_cnt, fifo_level and drop_err all 0. Reset mid-group discards the partial sum.
- Accumulate: on a prod_valid cycle, next_sum = acc + zero-extended prod_data, saturating at 2^ACC_W-1.
  - A group-local sat bit is set if any addition in the group clipped.
  - The group counter increments.
  - prod_valid=0 cycles leave all state unchanged; gaps within a group are allowed.
- Group close: when the counter reaches COUNT with this product, or when flush=1 and (counter>0 or prod_valid):
  - Push {next_sum, sat, count} at this clock edge.
  - Clear acc, sat and counter in the same cycle.
  - flush with an empty group and no prod_valid does nothing.
  - flush on the same cycle as the COUNT-th product produces exactly one push.
- Latency: closing product sampled at edge t; res_valid=1 with that result after edge t, if the FIFO was empty.
- Output handshake:
  - Pop when res_valid && res_ready.
  - res_data, res_sat and res_cnt reflect the head combinationally from FIFO storage.
  - They hold stable while res_valid=1 and res_ready=0.
- FIFO full:
  - Push with fifo_level==DEPTH and no pop in the same cycle: the result is dropped, drop_err is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both succeed; level stays DEPTH.
- FIFO empty: res_valid=0 and res_data, res_sat, res_cnt read as 0. A push in the same cycle is visible only after the edge; there is no bypass.
- Pointer wrap: pointers are clog2(DEPTH)+1 bits wide. Full/empty comes from the MSB compare; level = wr - rd.
- drop_err: cleared by clr_err. If a drop and clr_err occur in the same cycle, the set wins.
- Saturated sums stay pinned at max for the rest of the group.

Decomposition:
- Package mul_acc_pkg holds:
  - Default widths.
  - The result-entry struct: data, sat, cnt.
  - The function for clog2-based pointer width.
- One natural sub-module, mul_acc_fifo: synchronous FIFO with push/pop, full/empty and level, and drop on full-without-pop.
- The top holds the accumulator and group counter and instantiates the FIFO.

Test Plan:
- Four back-to-back products 100, 200, 300, 400, res_ready=1 -> one result, res_data=1000, res_cnt=4, res_sat=0, res_valid one cycle after the 4th product.
- Products 255*255=65025 four times, ACC_W=17 -> res_data=131071, res_sat=1.
- Products 5, gap 3 cycles, 7, then flush alone -> res_data=12, res_cnt=2; a second flush with an empty group -> no push.
- res_ready=0, feed 5 full groups of value 1 each -> fifo_level=4, drop_err=1, results 4,4,4,4 drain in order. clr_err -> drop_err=0.
- FIFO full, res_ready=1 while a 5th group closes -> no drop, level stays 4, drop_err stays 0.
- Assert rst_n after 2 of 4 products, then feed 4 products of 10 -> res_data=40; outputs read 0 during reset.
